// File: rtl/bsg_downstream_pkg.sv
// Shared FSM type and width helpers for the parametrised downstream channel.
package bsg_downstream_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Extra MSB distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int word_w(input int io_w, input int gather);
    return io_w * gather;
  endfunction

  function automatic int core_w(input int io_w, input int gather, input int core_beats);
    return io_w * gather * core_beats;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_downstream_fifo_mem.sv
// DEPTH x WORD_W register array: one synchronous write port, one combinational read port.
module bsg_downstream_fifo_mem
  import bsg_downstream_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [WORD_W-1:0]          wdata,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [WORD_W-1:0]          rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Storage write; contents are only read while the FIFO is non-empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/bsg_downstream_channel_param.sv
// Downstream channel: gathers IO beats into FIFO words, assembles CORE_BEATS words per core output.
// Define BSG_DOWN_OVERFLOW_CNT_EN to add the saturating dropped-word counter ovf_count_o.
module bsg_downstream_channel_param
  import bsg_downstream_pkg::*;
#(
  parameter int IO_W       = 8,
  parameter int GATHER     = 2,
  parameter int DEPTH      = 8,
  parameter int CORE_BEATS = 2,
  parameter int TOKEN_DIV  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  io_valid_i,
  input  logic [IO_W-1:0]                       io_data_i,
  output logic                                  io_token_o,
  output logic                                  core_valid_o,
  output logic [IO_W*GATHER*CORE_BEATS-1:0]     core_data_o,
  input  logic                                  core_ready_i,
  output logic                                  full_o,
`ifdef BSG_DOWN_OVERFLOW_CNT_EN
  output logic [7:0]                            ovf_count_o,
`endif
  output logic                                  overflow_o
);

  localparam int WORD_W = word_w(IO_W, GATHER);
  localparam int CORE_W = core_w(IO_W, GATHER, CORE_BEATS);
  localparam int AW     = addr_w(DEPTH);
  localparam int PW     = ptr_w(DEPTH);
  localparam int GW     = cnt_w(GATHER);
  localparam int ACW    = cnt_w(CORE_BEATS);
  localparam int TW     = cnt_w(TOKEN_DIV);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if ((GATHER < 1) || (CORE_BEATS < 1) || (TOKEN_DIV < 1) || (TOKEN_DIV > DEPTH)) begin : g_bad_cfg
    $error("GATHER, CORE_BEATS, TOKEN_DIV must be >= 1 and TOKEN_DIV <= DEPTH");
  end

  logic [GW-1:0]     gcnt_r;
  logic [WORD_W-1:0] gbuf_r;
  logic [WORD_W-1:0] wdata_s;
  logic [WORD_W-1:0] rdata_s;
  logic [PW-1:0]     wptr_r;
  logic [PW-1:0]     rptr_r;
  logic [ACW-1:0]    acnt_r;
  logic [TW-1:0]     tcnt_r;
  logic [CORE_W-1:0] core_data_r;
  logic              core_valid_r;
  logic              token_r;
  logic              overflow_r;
  logic              empty_s;
  logic              last_beat_s;
  logic              wr_s;
  logic              drop_s;
  logic              pop_s;
  state_e            state_r;
  state_e            state_n;

  assign empty_s     = (wptr_r == rptr_r);
  assign full_o      = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
  assign last_beat_s = io_valid_i && (gcnt_r == GW'(GATHER - 1));
  assign wr_s        = last_beat_s && !full_o;
  assign drop_s      = last_beat_s && full_o;

  // Current beat merged into the partial word; on the last beat this is the word to write.
  always_comb begin
    wdata_s = gbuf_r;
    for (int i = 0; i < GATHER; i++) begin
      wdata_s[i*IO_W +: IO_W] = (gcnt_r == GW'(i)) ? io_data_i : gbuf_r[i*IO_W +: IO_W];
    end
  end

  // Gather counter and partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_r <= GW'(0);
      gbuf_r <= WORD_W'(0);
    end else if (io_valid_i) begin
      gbuf_r <= wdata_s;
      gcnt_r <= last_beat_s ? GW'(0) : gcnt_r + GW'(1);
    end
  end

  bsg_downstream_fifo_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_s),
    .waddr (wptr_r[AW-1:0]),
    .wdata (wdata_s),
    .raddr (rptr_r[AW-1:0]),
    .rdata (rdata_s)
  );

  // FIFO pointers and sticky overflow flag; full is judged before any same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r     <= PW'(0);
      rptr_r     <= PW'(0);
      overflow_r <= 1'b0;
    end else begin
      if (wr_s)   wptr_r     <= wptr_r + PW'(1);
      if (pop_s)  rptr_r     <= rptr_r + PW'(1);
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Assembler next-state and pop decision.
  always_comb begin
    state_n = state_r;
    pop_s   = 1'b0;
    case (state_r)
      FILL: begin
        pop_s = !empty_s;
        if (pop_s && (acnt_r == ACW'(CORE_BEATS - 1))) state_n = OUT;
        else                                           state_n = FILL;
      end
      OUT: begin
        if (core_ready_i) state_n = FILL;
        else              state_n = OUT;
      end
      default: state_n = FILL;
    endcase
  end

  // Assembler state, slot fill and output valid; data is frozen while in OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      acnt_r       <= ACW'(0);
      core_data_r  <= CORE_W'(0);
      core_valid_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      core_valid_r <= (state_n == OUT);
      if (pop_s) begin
        for (int i = 0; i < CORE_BEATS; i++) begin
          if (acnt_r == ACW'(i)) core_data_r[i*WORD_W +: WORD_W] <= rdata_s;
        end
        acnt_r <= (acnt_r == ACW'(CORE_BEATS - 1)) ? ACW'(0) : acnt_r + ACW'(1);
      end
    end
  end

  // Credit token: one toggle per TOKEN_DIV pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r  <= TW'(0);
      token_r <= 1'b0;
    end else if (pop_s) begin
      if (tcnt_r == TW'(TOKEN_DIV - 1)) begin
        tcnt_r  <= TW'(0);
        token_r <= ~token_r;
      end else begin
        tcnt_r  <= tcnt_r + TW'(1);
      end
    end
  end

`ifdef BSG_DOWN_OVERFLOW_CNT_EN
  logic [7:0] ovf_cnt_r;

  // Saturating count of dropped words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= 8'd0;
    end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end
  end

  assign ovf_count_o = ovf_cnt_r;
`endif

  assign io_token_o   = token_r;
  assign core_valid_o = core_valid_r;
  assign core_data_o  = core_data_r;
  assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_bsg_downstream_channel_param.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_bsg_downstream_channel_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_valid;
  logic [7:0]  io_data;
  logic        io_token;
  logic        core_valid;
  logic [31:0] core_data;
  logic        core_ready;
  logic        full;
  logic        overflow;
  logic        v6;
  logic [7:0]  d6;
  logic        r6;
  logic        tok6;
  logic        cv6;
  logic [31:0] cd6;
  logic        full6;
  logic        ovf6;
`ifdef BSG_DOWN_OVERFLOW_CNT_EN
  logic [7:0]  ovf_count;
  logic [7:0]  oc6;
`endif

  always #5 clk = ~clk;

  bsg_downstream_channel_param u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_valid_i   (io_valid),
    .io_data_i    (io_data),
    .io_token_o   (io_token),
    .core_valid_o (core_valid),
    .core_data_o  (core_data),
    .core_ready_i (core_ready),
    .full_o       (full),
`ifdef BSG_DOWN_OVERFLOW_CNT_EN
    .ovf_count_o  (ovf_count),
`endif
    .overflow_o   (overflow)
  );

  bsg_downstream_channel_param #(
    .GATHER(1), .CORE_BEATS(4), .TOKEN_DIV(1)
  ) u_dut6 (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_valid_i   (v6),
    .io_data_i    (d6),
    .io_token_o   (tok6),
    .core_valid_o (cv6),
    .core_data_o  (cd6),
    .core_ready_i (r6),
    .full_o       (full6),
`ifdef BSG_DOWN_OVERFLOW_CNT_EN
    .ovf_count_o  (oc6),
`endif
    .overflow_o   (ovf6)
  );

  int checks = 0;
  int failures = 0;

  // Reference model of the default configuration (8-bit beats, 16-bit words, 8 deep, 2 words out, token/4).
  logic [15:0] mq[$];
  int          mg;
  logic [7:0]  mgb;
  int          mac;
  logic [15:0] mslot0;
  bit          mout;
  logic [31:0] mdata;
  int          mtc;
  bit          mtok;
  bit          movf;
  int          mocnt;

  logic [31:0] dut_out[$];
  logic [7:0]  sent[$];
  int          tok_toggles;
  int          tok6_toggles;
  bit          ever_full;
  logic        prev_tok;
  logic        prev_tok6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mg = 0; mgb = 8'h00; mac = 0; mslot0 = 16'h0000;
    mout = 1'b0; mdata = 32'h0; mtc = 0; mtok = 1'b0; movf = 1'b0; mocnt = 0;
  endtask

  // Apply one clock edge to the model using the inputs that were stable before it.
  task automatic model_step();
    bit          full_pre;
    logic [15:0] w;
    full_pre = (mq.size() == 8);
    if (!mout && mq.size() > 0) begin
      w = mq.pop_front();
      if (mac == 0) begin
        mslot0 = w;
        mac = 1;
      end else begin
        mdata = {w, mslot0};
        mac = 0;
        mout = 1'b1;
      end
      mtc++;
      if (mtc == 4) begin
        mtc = 0;
        mtok = ~mtok;
      end
    end else if (mout && core_ready) begin
      mout = 1'b0;
    end
    if (io_valid) begin
      if (mg == 0) begin
        mgb = io_data;
        mg = 1;
      end else begin
        mg = 0;
        if (!full_pre) mq.push_back({io_data, mgb});
        else begin
          movf = 1'b1;
          if (mocnt < 255) mocnt++;
        end
      end
    end
  endtask

  task automatic compare();
    check("core_valid", {31'd0, core_valid}, {31'd0, mout});
    if (mout) check("core_data", core_data, mdata);
    check("full", {31'd0, full}, {31'd0, (mq.size() == 8)});
    check("overflow", {31'd0, overflow}, {31'd0, movf});
    check("io_token", {31'd0, io_token}, {31'd0, mtok});
`ifdef BSG_DOWN_OVERFLOW_CNT_EN
    check("ovf_count", {24'd0, ovf_count}, 32'(mocnt));
`endif
  endtask

  task automatic cycle();
    if (core_valid && core_ready) dut_out.push_back(core_data);
    prev_tok  = io_token;
    prev_tok6 = tok6;
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (io_token != prev_tok) tok_toggles++;
    if (tok6 != prev_tok6) tok6_toggles++;
    if (full) ever_full = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic beat(input logic [7:0] b);
    io_valid = 1'b1;
    io_data  = b;
    sent.push_back(b);
    cycle();
    io_valid = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    io_valid = 1'b0; io_data = 8'h00; v6 = 1'b0; d6 = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    check("rst_core_valid", {31'd0, core_valid}, 32'd0);
    check("rst_core_data", core_data, 32'd0);
    check("rst_token_full_ovf", {29'd0, io_token, full, overflow}, 32'd0);
    check("rst_dut6_outputs", {28'd0, tok6, cv6, full6, ovf6}, 32'd0);
    model_clear();
    dut_out.delete(); sent.delete();
    tok_toggles = 0; tok6_toggles = 0; ever_full = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    rst_n = 1'b1; io_valid = 1'b0; io_data = 8'h00; core_ready = 1'b0;
    v6 = 1'b0; d6 = 8'h00; r6 = 1'b1;
    model_clear();

    // 1: four bytes -> one 32-bit output
    do_reset();
    core_ready = 1'b1;
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    idle(6);
    check("t1_count", dut_out.size(), 32'd1);
    if (dut_out.size() > 0) check("t1_data", dut_out[0], 32'h44332211);
    check("t1_overflow", {31'd0, overflow}, 32'd0);

    // 2: back-pressure until full, 11th word dropped
    do_reset();
    core_ready = 1'b0;
    for (int i = 0; i < 22; i++) beat(8'(i + 1));
    idle(2);
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
`ifdef BSG_DOWN_OVERFLOW_CNT_EN
    check("t2_ovf_count", {24'd0, ovf_count}, 32'd1);
`endif
    core_ready = 1'b1;
    idle(30);
    check("t2_count", dut_out.size(), 32'd5);
    for (int k = 0; k < 5 && k < dut_out.size(); k++)
      check("t2_data", dut_out[k], {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)});
    check("t2_sticky", {30'd0, full, overflow}, 32'd1);

    // 3: token toggles every fourth pop
    do_reset();
    core_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(8'($urandom));
    idle(4);
    check("t3_token_after4", {31'd0, io_token}, 32'd1);
    for (int i = 0; i < 24; i++) beat(8'($urandom));
    idle(6);
    check("t3_toggles", tok_toggles, 32'd4);
    check("t3_token_final", {31'd0, io_token}, 32'd0);
    check("t3_outputs", dut_out.size(), 32'd8);

    // 4: partial traffic then async reset; no stale byte afterwards
    do_reset();
    core_ready = 1'b1;
    beat(8'h01); beat(8'h02); beat(8'h03);
    do_reset();
    beat(8'hAA); beat(8'hBB); beat(8'hCC); beat(8'hDD);
    idle(6);
    check("t4_count", dut_out.size(), 32'd1);
    if (dut_out.size() > 0) check("t4_data", dut_out[0], 32'hDDCCBBAA);

    // 5: 80 bytes with ready toggling; loss-free and in order
    do_reset();
    for (int i = 0; i < 80; i++) begin
      core_ready = i[0];
      beat(8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      core_ready = ~core_ready;
      cycle();
    end
    check("t5_count", dut_out.size(), 32'd20);
    for (int k = 0; k < dut_out.size() && k < 20; k++)
      check("t5_data", dut_out[k], {sent[4*k+3], sent[4*k+2], sent[4*k+1], sent[4*k]});
    check("t5_no_full_ovf", {30'd0, ever_full, overflow}, 32'd0);

    // 6: GATHER=1, CORE_BEATS=4, TOKEN_DIV=1 instance
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      v6 = 1'b1;
      d6 = 8'(i);
      cycle();
    end
    v6 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (cv6) begin
        found = 1'b1;
        check("t6_data", cd6, 32'h04030201);
      end else begin
        cycle();
      end
    end
    check("t6_valid_seen", {31'd0, found}, 32'd1);
    check("t6_token_toggles", tok6_toggles, 32'd4);

    // Random traffic: low-ready phase provokes drops, then high-ready drain
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      io_valid   = ($urandom_range(0, 9) < 6);
      io_data    = 8'($urandom);
      core_ready = (i < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
    end
    io_valid = 1'b0;
    core_ready = 1'b1;
    idle(40);
    check("rand_drained", {31'd0, core_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_downstream_channel_param.md
Name: bsg_downstream_channel_param

Overview:
Parametrised single-clock downstream channel for the off-chip link. It gathers narrow IO beats into FIFO words and buffers them in a DEPTH-entry FIFO. It assembles CORE_BEATS words into one core-side output under a valid/ready handshake, and returns flow-control tokens to the upstream sender. It sits between the IO receive pads (already in clk domain) and the core fabric, and generalises the fixed 8-bit/16-bit/32-bit, 8-entry downstream channel.

Parameters:
IO_W, 8, IO beat width in bits
GATHER, 2, IO beats per FIFO word (WORD_W = IO_W*GATHER)
DEPTH, 8, FIFO entries; power of 2, >=2
CORE_BEATS, 2, FIFO words per core output (CORE_W = WORD_W*CORE_BEATS)
TOKEN_DIV, 4, FIFO pops per token toggle; 1..DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
io_valid_i  in  1  IO beat valid
io_data_i  in  IO_W  IO beat data
io_token_o  out  1  credit token to upstream; toggles per TOKEN_DIV pops
core_valid_o  out  1  assembled output valid
core_data_o  out  CORE_W  assembled output data
core_ready_i  in  1  core accepts output
full_o  out  1  FIFO full
overflow_o  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset: the clock is clk; reset is asynchronous, active-low, on rst_n. Asserting rst_n clears all state immediately: outputs 0, pointers 0, gather and assembly counters 0, FSM = FILL.
- Gather: counter gcnt counts 0..GATHER-1.
  - Each cycle with io_valid_i, beat gcnt is stored at bits [gcnt*IO_W +: IO_W], so beat 0 lands in the LSBs.
  - On the last beat, the word {beat_last,...,beat0} is written at wptr if !full_o, and gcnt returns to 0.
  - If full_o is set on the last beat, the word is dropped, overflow_o is set (sticky until reset), and gcnt still returns to 0.
- FIFO pointers: wptr and rptr are clog2(DEPTH)+1 bits wide.
  - empty when wptr == rptr.
  - full_o when the address bits are equal and the MSBs differ. full_o is combinational from the registered pointers.
  - A pop in the same cycle does not free space for a write that cycle.
  - A simultaneous write and pop are both performed.
  - A written word is poppable from the next cycle.
- Assembler FSM:
  - FILL: pop one word per cycle while !empty. The word goes to slot acnt at [acnt*WORD_W +: WORD_W]. When the pop of slot CORE_BEATS-1 occurs, go to OUT next cycle with core_valid_o=1 and acnt=0.
  - OUT: no pops. core_data_o stays stable while core_valid_o && !core_ready_i. When core_ready_i is high, core_valid_o is cleared and the FSM returns to FILL; it can pop that same next cycle.
  - Minimum latency from last IO beat to core_valid_o: 2 cycles when CORE_BEATS=1.
- Token: counter tcnt counts 0..TOKEN_DIV-1 and increments per pop. On the pop where tcnt == TOKEN_DIV-1, io_token_o toggles and tcnt returns to 0.
- Elaboration checks: DEPTH power of 2; GATHER, CORE_BEATS, TOKEN_DIV >= 1; TOKEN_DIV <= DEPTH.

Optional Feature:
BSG_DOWN_OVERFLOW_CNT_EN
- Defined: adds output port ovf_count_o [7:0]. It is a saturating count (max 255) of dropped words, cleared only by reset; overflow_o is unchanged.
- Undefined: the port and counter are absent, and only the sticky overflow_o flag exists.

Decomposition:
- Package bsg_downstream_pkg holds:
  - the FSM enum {FILL, OUT};
  - localparam helpers for pointer width (clog2(DEPTH)+1), WORD_W and CORE_W.
- Sub-module bsg_downstream_fifo_mem: DEPTH x WORD_W register array with one synchronous write port and one combinational read port addressed by rptr[clog2(DEPTH)-1:0]. Pointer, flag, FSM and token logic stay in the top.

Test Plan:
1. Defaults, core_ready_i=1; bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one pulse with core_valid_o=1 and core_data_o=0x44332211; overflow_o=0.
2. core_ready_i=0; send 22 bytes (11 words):
   - assembler holds 2 words and the FIFO holds 8, so full_o=1 after the 10th word;
   - the 11th word is dropped and overflow_o=1;
   - after core_ready_i=1, outputs are the first five word pairs in order.
3. Defaults; stream 16 words with ready=1 -> io_token_o toggles 0->1 on the 4th pop, ->0 on the 8th, ->1 on the 12th, ->0 on the 16th.
4. Send bytes 0x01,0x02,0x03; pulse rst_n low mid-cycle -> all outputs 0 asynchronously. Then send 0xAA,0xBB,0xCC,0xDD -> core_data_o=0xDDCCBBAA with no stale byte.
5. Stream 80 bytes with ready toggling 1/0 each cycle -> 20 outputs, in order and loss-free; pointers wrap at least twice; full_o/overflow_o never set.
6. GATHER=1, CORE_BEATS=4, TOKEN_DIV=1; bytes 0x01..0x04 -> core_data_o=0x04030201; io_token_o toggles on every pop.
   - With BSG_DOWN_OVERFLOW_CNT_EN defined, rerun scenario 2 -> ovf_count_o=1.
